// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-command signals shared by the fetch requester,
// the load/store requester and the unified RAM around mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              rd_ram_en;
  logic [ADDR_W-1:0] rd_ram_addr;
  logic [DATA_W-1:0] rd_ram_data;
  logic              wr_ram_en;
  logic [ADDR_W-1:0] wr_ram_addr;
  logic [DATA_W-1:0] wr_ram_data;

  // The arbiter's view of the bus.
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, rd_ram_data,
    output if_gnt, if_stall, if_rvalid, if_rdata,
           ls_gnt, ls_rvalid, ls_rdata,
           rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data
  );

  // The requesters' and RAM's combined view of the bus.
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, rd_ram_data,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
           ls_gnt, ls_rvalid, ls_rdata,
           rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto the unified RAM's read and
// write ports, and routes each read response back to the requester that issued it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              same_word;
  logic              load_conflict;
  logic              fetch_wins;
  logic              rd_grant;
  logic              wr_grant;
  logic [3:0]        starve_cnt;

  logic              rd_en_q;
  logic              rd_owner_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_owner;

  // A store to the word being fetched must land before the fetch reads it.
  assign same_word     = bus.if_req && bus.ls_req && bus.ls_we &&
                         (bus.if_addr[ADDR_W-1:2] == bus.ls_addr[ADDR_W-1:2]);
  assign load_conflict = bus.if_req && bus.ls_req && !bus.ls_we;
  assign fetch_wins    = (starve_cnt == STARVE_LIM);

  assign bus.ls_gnt   = reset_n && bus.ls_req && !(load_conflict && fetch_wins);
  assign bus.if_gnt   = reset_n && bus.if_req && !same_word &&
                        !(load_conflict && !fetch_wins);
  assign bus.if_stall = reset_n && bus.if_req && !bus.if_gnt;

  assign rd_grant = bus.if_gnt || (bus.ls_gnt && !bus.ls_we);
  assign wr_grant = bus.ls_gnt && bus.ls_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (bus.if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (bus.if_stall && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Address and data registers hold their last command when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_q    <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      rd_en_q <= rd_grant;
      wr_en_q <= wr_grant;
      if (rd_grant) begin
        rd_owner_q <= !bus.if_gnt;
        rd_addr_q  <= bus.if_gnt ? bus.if_addr : bus.ls_addr;
      end
      if (wr_grant) begin
        wr_addr_q <= bus.ls_addr;
        wr_data_q <= bus.ls_wdata;
      end
    end
  end

  // Tags follow the issued read command so the tail lines up with RAM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= rd_en_q;
      tag_owner[0] <= rd_owner_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign bus.rd_ram_en   = rd_en_q;
  assign bus.rd_ram_addr = rd_addr_q;
  assign bus.wr_ram_en   = wr_en_q;
  assign bus.wr_ram_addr = wr_addr_q;
  assign bus.wr_ram_data = wr_data_q;

  assign bus.if_rvalid = tag_valid[RD_LATENCY-1] && !tag_owner[RD_LATENCY-1];
  assign bus.ls_rvalid = tag_valid[RD_LATENCY-1] &&  tag_owner[RD_LATENCY-1];
  assign bus.if_rdata  = bus.rd_ram_data;
  assign bus.ls_rdata  = bus.rd_ram_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table on a latency-1 instance,
// then reset-in-flight and latency-3 alternating-owner sequences.
module tb_mem_port_arbiter;

  localparam int NV = 28;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        exp_if_gnt;
    logic        exp_ls_gnt;
    logic        exp_if_stall;
  } vec_t;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_bus)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int k);
    return (k == 32'h40) ? 32'hDEADBEEF : (32'hA000_0000 | k);
  endfunction

  // RAM shared by both instances: dut_a has latency 1, dut_b latency 3.
  logic [31:0] mem [0:1023];
  logic [31:0] ram_a_q, b_p0, b_p1, b_p2;
  assign a_bus.rd_ram_data = ram_a_q;
  assign b_bus.rd_ram_data = b_p2;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = initWord(k);
    ram_a_q = '0; b_p0 = '0; b_p1 = '0; b_p2 = '0;
    forever begin
      @(posedge clk);
      if (a_bus.rd_ram_en) ram_a_q <= mem[a_bus.rd_ram_addr[11:2]];
      if (b_bus.rd_ram_en) b_p0 <= mem[b_bus.rd_ram_addr[11:2]];
      b_p1 <= b_p0;
      b_p2 <= b_p1;
      if (a_bus.wr_ram_en) mem[a_bus.wr_ram_addr[11:2]] = a_bus.wr_ram_data;
    end
  end

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic lr, logic lw,
                              logic [31:0] la, logic [31:0] ld,
                              logic eig, logic elg, logic est);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw;
    v.ls_addr = la; v.ls_wdata = ld;
    v.exp_if_gnt = eig; v.exp_ls_gnt = elg; v.exp_if_stall = est;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_bus.if_req   = v.if_req;
    a_bus.if_addr  = v.if_addr;
    a_bus.ls_req   = v.ls_req;
    a_bus.ls_we    = v.ls_we;
    a_bus.ls_addr  = v.ls_addr;
    a_bus.ls_wdata = v.ls_wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [NV];
  vec_t        idle, cont;
  logic        e_rd_en  [NV+2];
  logic [31:0] e_rd_addr[NV+2];
  logic        e_wr_en  [NV+2];
  logic [31:0] e_wr_addr[NV+2];
  logic [31:0] e_wr_data[NV+2];
  logic        e_if_rv  [NV+2];
  logic        e_ls_rv  [NV+2];
  logic [31:0] e_rdata  [NV+2];
  logic [31:0] model_mem[0:1023];

  initial begin
    logic [31:0] cur_rd_addr, cur_wr_addr, cur_wr_data;
    logic [31:0] ra;

    idle = mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    cont = mk(1, 32'h200, 1, 0, 32'h300, 32'h0, 0, 1, 1);
    for (int i = 0; i < 10; i++) vecs[i] = cont;
    vecs[4]  = mk(1, 32'h200, 1, 0, 32'h300, 32'h0, 1, 0, 0);
    vecs[9]  = vecs[4];
    vecs[10] = idle;
    vecs[11] = mk(1, 32'h100, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    vecs[12] = idle;
    vecs[13] = idle;
    vecs[14] = mk(1, 32'h42, 1, 1, 32'h40, 32'h11, 0, 1, 1);
    vecs[15] = mk(1, 32'h42, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    vecs[16] = mk(1, 32'h80, 1, 1, 32'h40, 32'h22, 1, 1, 0);
    vecs[17] = idle;
    vecs[18] = idle;
    vecs[19] = cont;
    vecs[20] = idle;
    vecs[21] = cont;
    vecs[22] = cont;
    vecs[23] = cont;
    vecs[24] = vecs[4];
    vecs[25] = mk(0, 32'h0, 1, 0, 32'h300, 32'h0, 0, 1, 0);
    vecs[26] = idle;
    vecs[27] = idle;

    // Expected RAM commands and responses derived from the expected grants.
    for (int k = 0; k < 1024; k++) model_mem[k] = initWord(k);
    for (int i = 0; i < NV + 2; i++) begin
      e_rd_en[i] = 0; e_wr_en[i] = 0; e_if_rv[i] = 0; e_ls_rv[i] = 0;
      e_rdata[i] = '0; e_rd_addr[i] = '0; e_wr_addr[i] = '0; e_wr_data[i] = '0;
    end
    cur_rd_addr = '0; cur_wr_addr = '0; cur_wr_data = '0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].exp_if_gnt || (vecs[i].exp_ls_gnt && !vecs[i].ls_we)) begin
        ra = vecs[i].exp_if_gnt ? vecs[i].if_addr : vecs[i].ls_addr;
        cur_rd_addr = ra;
        e_rd_en[i+1] = 1;
        if (i + 2 < NV + 2) begin
          e_if_rv[i+2] = vecs[i].exp_if_gnt;
          e_ls_rv[i+2] = !vecs[i].exp_if_gnt;
          e_rdata[i+2] = model_mem[ra[11:2]];
        end
      end
      if (vecs[i].exp_ls_gnt && vecs[i].ls_we) begin
        e_wr_en[i+1] = 1;
        cur_wr_addr = vecs[i].ls_addr;
        cur_wr_data = vecs[i].ls_wdata;
        model_mem[cur_wr_addr[11:2]] = cur_wr_data;
      end
      e_rd_addr[i+1] = cur_rd_addr;
      e_wr_addr[i+1] = cur_wr_addr;
      e_wr_data[i+1] = cur_wr_data;
    end

    b_bus.if_req = 0; b_bus.if_addr = '0; b_bus.ls_req = 0;
    b_bus.ls_we = 0; b_bus.ls_addr = '0; b_bus.ls_wdata = '0;

    // Reset state, with both requests asserted to show grants are suppressed.
    reset_n = 0;
    applyStimulus(cont);
    @(negedge clk);
    checkOutput("rst_if_gnt", {31'b0, a_bus.if_gnt}, 0);
    checkOutput("rst_ls_gnt", {31'b0, a_bus.ls_gnt}, 0);
    checkOutput("rst_if_stall", {31'b0, a_bus.if_stall}, 0);
    checkOutput("rst_rd_en", {31'b0, a_bus.rd_ram_en}, 0);
    checkOutput("rst_wr_en", {31'b0, a_bus.wr_ram_en}, 0);
    checkOutput("rst_rd_addr", a_bus.rd_ram_addr, 0);
    checkOutput("rst_wr_addr", a_bus.wr_ram_addr, 0);
    checkOutput("rst_wr_data", a_bus.wr_ram_data, 0);
    checkOutput("rst_rvalid", {30'b0, a_bus.if_rvalid, a_bus.ls_rvalid}, 0);
    applyStimulus(idle);
    nextCycle();
    reset_n = 1;

    // Vector table, one vector per cycle.
    for (int i = 0; i < NV; i++) begin
      nextCycle();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_if_gnt", i), {31'b0, a_bus.if_gnt}, {31'b0, vecs[i].exp_if_gnt});
      checkOutput($sformatf("v%0d_ls_gnt", i), {31'b0, a_bus.ls_gnt}, {31'b0, vecs[i].exp_ls_gnt});
      checkOutput($sformatf("v%0d_if_stall", i), {31'b0, a_bus.if_stall}, {31'b0, vecs[i].exp_if_stall});
      checkOutput($sformatf("v%0d_rd_en", i), {31'b0, a_bus.rd_ram_en}, {31'b0, e_rd_en[i]});
      checkOutput($sformatf("v%0d_rd_addr", i), a_bus.rd_ram_addr, e_rd_addr[i]);
      checkOutput($sformatf("v%0d_wr_en", i), {31'b0, a_bus.wr_ram_en}, {31'b0, e_wr_en[i]});
      checkOutput($sformatf("v%0d_wr_addr", i), a_bus.wr_ram_addr, e_wr_addr[i]);
      checkOutput($sformatf("v%0d_wr_data", i), a_bus.wr_ram_data, e_wr_data[i]);
      checkOutput($sformatf("v%0d_if_rvalid", i), {31'b0, a_bus.if_rvalid}, {31'b0, e_if_rv[i]});
      checkOutput($sformatf("v%0d_ls_rvalid", i), {31'b0, a_bus.ls_rvalid}, {31'b0, e_ls_rv[i]});
      if (e_if_rv[i]) checkOutput($sformatf("v%0d_if_rdata", i), a_bus.if_rdata, e_rdata[i]);
      if (e_ls_rv[i]) checkOutput($sformatf("v%0d_ls_rdata", i), a_bus.ls_rdata, e_rdata[i]);
    end

    // Reset while a load is in flight; starve count is raised to 2 first.
    nextCycle();
    applyStimulus(cont);
    nextCycle();
    applyStimulus(cont);
    @(negedge clk);
    checkOutput("mid_ls_gnt", {31'b0, a_bus.ls_gnt}, 1);
    nextCycle();
    reset_n = 0;
    @(negedge clk);
    checkOutput("mid_rd_en_in_reset", {31'b0, a_bus.rd_ram_en}, 0);
    checkOutput("mid_if_gnt_in_reset", {31'b0, a_bus.if_gnt}, 0);
    checkOutput("mid_ls_gnt_in_reset", {31'b0, a_bus.ls_gnt}, 0);
    checkOutput("mid_stall_in_reset", {31'b0, a_bus.if_stall}, 0);
    checkOutput("mid_ls_rvalid_in_reset", {31'b0, a_bus.ls_rvalid}, 0);
    nextCycle();
    reset_n = 1;
    applyStimulus(idle);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("mid_ls_rvalid_after_%0d", c), {31'b0, a_bus.ls_rvalid}, 0);
      nextCycle();
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(cont);
      @(negedge clk);
      checkOutput($sformatf("mid_starve_if_gnt_%0d", c), {31'b0, a_bus.if_gnt}, (c == 4) ? 1 : 0);
      checkOutput($sformatf("mid_starve_ls_gnt_%0d", c), {31'b0, a_bus.ls_gnt}, (c == 4) ? 0 : 1);
      nextCycle();
    end
    applyStimulus(idle);

    // Latency-3 instance: alternating fetch/load grants, responses at issue+4.
    for (int c = 0; c < 12; c++) begin
      int j;
      if (c < 6) begin
        b_bus.if_req  = (c % 2 == 0);
        b_bus.if_addr = 32'h400 + 32'(4 * c);
        b_bus.ls_req  = (c % 2 == 1);
        b_bus.ls_addr = 32'h600 + 32'(4 * c);
      end else begin
        b_bus.if_req = 0;
        b_bus.ls_req = 0;
      end
      @(negedge clk);
      if (c < 6) begin
        checkOutput($sformatf("b%0d_if_gnt", c), {31'b0, b_bus.if_gnt}, (c % 2 == 0) ? 1 : 0);
        checkOutput($sformatf("b%0d_ls_gnt", c), {31'b0, b_bus.ls_gnt}, (c % 2 == 1) ? 1 : 0);
      end
      j = c - 4;
      checkOutput($sformatf("b%0d_if_rvalid", c), {31'b0, b_bus.if_rvalid},
                  (j >= 0 && j < 6 && j % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("b%0d_ls_rvalid", c), {31'b0, b_bus.ls_rvalid},
                  (j >= 0 && j < 6 && j % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("b%0d_both_rvalid", c), {31'b0, b_bus.if_rvalid && b_bus.ls_rvalid}, 0);
      if (j >= 0 && j < 6 && j % 2 == 0)
        checkOutput($sformatf("b%0d_if_rdata", c), b_bus.if_rdata, initWord(32'h100 + j));
      if (j >= 0 && j < 6 && j % 2 == 1)
        checkOutput($sformatf("b%0d_ls_rdata", c), b_bus.ls_rdata, initWord(32'h180 + j));
      nextCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
